// File: rtl/cpu_execute_mc_if.sv
// Stage-2 to stage-3 execute bus: decoded control and operands in, _3a pipeline registers out.
interface cpu_execute_mc_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned TW = 35,
  parameter int unsigned IW = 48,
  parameter int unsigned AW = 8,
  parameter int unsigned PW = 11
);
  logic          valid_2a;
  logic [4:0]    alu_op_2a;
  logic [1:0]    c_alu_left_2a;
  logic [1:0]    c_alu_right_2a;
  logic [1:0]    c_branch_2a;
  logic          c_mem_write_2a;
  logic [2:0]    c_to_push_2a;
  logic          c_r0_2a;
  logic          c_r1_2a;
  logic [IW-1:0] instruction_2a;
  logic [DW-1:0] pc_2a;
  logic [DW-1:0] pc_1a;
  logic [TW-1:0] st_top_0_2a;
  logic [TW-1:0] st_top_n_2a;
  logic [PW-1:0] st_to_pop_2a;
  logic          kill_4a;
  logic          stall_2a;
  logic          valid_3a;
  logic          alu_cond_3a;
  logic          c_mem_write_3a;
  logic [DW-1:0] alu_out_3a;
  logic [DW-1:0] pc_3a;
  logic [IW-1:0] instruction_3a;
  logic [1:0]    c_branch_3a;
  logic [2:0]    c_to_push_3a;
  logic [AW-1:0] c_mem_addr_3a;
  logic [TW-1:0] r0_3a;
  logic [TW-1:0] r1_3a;
  logic [PW-1:0] st_to_pop_3a;

  modport master (
    output valid_2a, alu_op_2a, c_alu_left_2a, c_alu_right_2a, c_branch_2a, c_mem_write_2a,
    output c_to_push_2a, c_r0_2a, c_r1_2a, instruction_2a, pc_2a, pc_1a, st_top_0_2a,
    output st_top_n_2a, st_to_pop_2a, kill_4a,
    input  stall_2a, valid_3a, alu_cond_3a, c_mem_write_3a, alu_out_3a, pc_3a, instruction_3a,
    input  c_branch_3a, c_to_push_3a, c_mem_addr_3a, r0_3a, r1_3a, st_to_pop_3a
  );

  modport slave (
    input  valid_2a, alu_op_2a, c_alu_left_2a, c_alu_right_2a, c_branch_2a, c_mem_write_2a,
    input  c_to_push_2a, c_r0_2a, c_r1_2a, instruction_2a, pc_2a, pc_1a, st_top_0_2a,
    input  st_top_n_2a, st_to_pop_2a, kill_4a,
    output stall_2a, valid_3a, alu_cond_3a, c_mem_write_3a, alu_out_3a, pc_3a, instruction_3a,
    output c_branch_3a, c_to_push_3a, c_mem_addr_3a, r0_3a, r1_3a, st_to_pop_3a
  );
endinterface

// File: rtl/cpu_execute_mc.sv
// Execute stage: single-cycle ALU plus iterative unsigned MUL (and DIVU/REMU when
// CPU_EXEC_DIV_EN is defined; otherwise DIVU/REMU are single-cycle, result 0, cond 1).
module cpu_execute_mc #(
  parameter int unsigned DW = 32,
  parameter int unsigned TW = 35,
  parameter int unsigned IW = 48,
  parameter int unsigned AW = 8,
  parameter int unsigned PW = 11
) (
  input logic             clk,
  input logic             rst_b,
  cpu_execute_mc_if.slave bus
);
  localparam int unsigned CW = $clog2(DW + 1);
  localparam int unsigned SW = $clog2(DW);
  localparam logic [4:0] OpAdd = 5'h00, OpSub = 5'h01, OpAnd = 5'h02, OpOr = 5'h03;
  localparam logic [4:0] OpXor = 5'h04, OpShl = 5'h05, OpShr = 5'h06, OpLtu = 5'h07;
  localparam logic [4:0] OpEq = 5'h08, OpMul = 5'h18, OpDivu = 5'h19, OpRemu = 5'h1A;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] acc_hi_q, acc_lo_q, opb_q;
  logic [DW-1:0] opa, opb, alu_res, res_out, acc_hi_nx, acc_lo_nx;
  logic [DW:0]   mul_sum;
  logic          alu_cnd, cmp_op, cmp_val, res_cnd, is_mc, stall;

  always_comb begin
    unique case (bus.c_alu_left_2a)
      2'd0:    opa = bus.instruction_2a[DW-1:0];
      2'd1:    opa = bus.st_top_0_2a[DW-1:0];
      2'd2:    opa = bus.st_top_n_2a[DW-1:0];
      default: opa = bus.pc_1a;
    endcase
    unique case (bus.c_alu_right_2a)
      2'd0:    opb = bus.instruction_2a[DW-1:0];
      2'd1:    opb = bus.st_top_0_2a[DW-1:0];
      2'd2:    opb = bus.st_top_n_2a[DW-1:0];
      default: opb = bus.r1_3a[DW-1:0];
    endcase
  end

  // Single-cycle ALU; cond is the compare result for LTU/EQ, otherwise result==0.
  always_comb begin
    alu_res = opa;
    cmp_op  = 1'b0;
    cmp_val = 1'b0;
    case (bus.alu_op_2a)
      OpAdd: alu_res = opa + opb;
      OpSub: alu_res = opa - opb;
      OpAnd: alu_res = opa & opb;
      OpOr:  alu_res = opa | opb;
      OpXor: alu_res = opa ^ opb;
      OpShl: alu_res = opa << opb[SW-1:0];
      OpShr: alu_res = opa >> opb[SW-1:0];
      OpLtu: begin
        cmp_op  = 1'b1;
        cmp_val = opa < opb;
        alu_res = {{(DW-1){1'b0}}, cmp_val};
      end
      OpEq: begin
        cmp_op  = 1'b1;
        cmp_val = opa == opb;
        alu_res = {{(DW-1){1'b0}}, cmp_val};
      end
`ifndef CPU_EXEC_DIV_EN
      OpDivu, OpRemu: alu_res = '0;
`endif
      default: alu_res = opa;
    endcase
    alu_cnd = cmp_op ? cmp_val : (alu_res == '0);
  end

`ifdef CPU_EXEC_DIV_EN
  logic          div_q, rem_q, div_ge;
  logic [DW:0]   div_shift;
  assign is_mc = (bus.alu_op_2a == OpMul) || (bus.alu_op_2a == OpDivu) ||
                 (bus.alu_op_2a == OpRemu);
`else
  assign is_mc = (bus.alu_op_2a == OpMul);
`endif

  // MUL: {hi,lo} shifts right with lo holding the multiplier. DIV: hi=remainder, lo=quotient.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    acc_hi_nx = mul_sum[DW:1];
    acc_lo_nx = {mul_sum[0], acc_lo_q[DW-1:1]};
    res_out   = (state_q == StDone) ? acc_lo_q : alu_res;
    res_cnd   = (state_q == StDone) ? (acc_hi_q != '0) : alu_cnd;
`ifdef CPU_EXEC_DIV_EN
    div_shift = {acc_hi_q, acc_lo_q[DW-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    if (div_q || rem_q) begin
      acc_hi_nx = div_ge ? (div_shift[DW-1:0] - opb_q) : div_shift[DW-1:0];
      acc_lo_nx = {acc_lo_q[DW-2:0], div_ge};
      if (state_q == StDone) begin
        res_out = rem_q ? acc_hi_q : acc_lo_q;
        res_cnd = (opb_q == '0);
      end
    end
`endif
  end

  assign stall        = bus.valid_2a & is_mc & (state_q != StDone);
  assign bus.stall_2a = rst_b & stall;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q            <= StIdle;
      cnt_q              <= '0;
      acc_hi_q           <= '0;
      acc_lo_q           <= '0;
      opb_q              <= '0;
`ifdef CPU_EXEC_DIV_EN
      div_q              <= 1'b0;
      rem_q              <= 1'b0;
`endif
      bus.valid_3a       <= 1'b0;
      bus.alu_cond_3a    <= 1'b0;
      bus.c_mem_write_3a <= 1'b0;
      bus.alu_out_3a     <= '0;
      bus.pc_3a          <= '0;
      bus.instruction_3a <= '0;
      bus.c_branch_3a    <= '0;
      bus.c_to_push_3a   <= '0;
      bus.c_mem_addr_3a  <= '0;
      bus.r0_3a          <= '0;
      bus.r1_3a          <= '0;
      bus.st_to_pop_3a   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.valid_2a && is_mc && !bus.kill_4a) begin
            state_q  <= StBusy;
            cnt_q    <= CW'(DW);
            acc_hi_q <= '0;
            acc_lo_q <= opa;
            opb_q    <= opb;
`ifdef CPU_EXEC_DIV_EN
            div_q    <= (bus.alu_op_2a == OpDivu);
            rem_q    <= (bus.alu_op_2a == OpRemu);
`endif
          end
        end
        StBusy: begin
          if (bus.kill_4a) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            acc_hi_q <= acc_hi_nx;
            acc_lo_q <= acc_lo_nx;
            cnt_q    <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (!stall) begin
        bus.valid_3a       <= bus.valid_2a & ~bus.kill_4a;
        bus.alu_out_3a     <= res_out;
        bus.alu_cond_3a    <= res_cnd;
        bus.pc_3a          <= bus.pc_2a;
        bus.instruction_3a <= bus.instruction_2a;
        bus.c_mem_addr_3a  <= bus.st_top_n_2a[AW-1:0];
        bus.c_branch_3a    <= bus.kill_4a ? 2'b0 : bus.c_branch_2a;
        bus.c_mem_write_3a <= bus.c_mem_write_2a & ~bus.kill_4a;
        bus.c_to_push_3a   <= bus.kill_4a ? 3'b0 : bus.c_to_push_2a;
        bus.st_to_pop_3a   <= bus.kill_4a ? '0 : bus.st_to_pop_2a;
        if (bus.c_r0_2a && !bus.kill_4a) bus.r0_3a <= bus.st_top_0_2a;
        if (bus.c_r1_2a && !bus.kill_4a) bus.r1_3a <= bus.st_top_n_2a;
      end else begin
        bus.valid_3a       <= 1'b0;
        bus.c_branch_3a    <= '0;
        bus.c_mem_write_3a <= 1'b0;
        bus.c_to_push_3a   <= '0;
        bus.st_to_pop_3a   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_cpu_execute_mc.sv
// Bench for cpu_execute_mc: cycle-level reference model plus directed literal checks.
module tb_cpu_execute_mc;
  localparam int unsigned DW = 32, TW = 35, IW = 48, AW = 8, PW = 11;
`ifdef CPU_EXEC_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif
  localparam logic [4:0] ADD = 5'h00, SUB = 5'h01, LTU = 5'h07;
  localparam logic [4:0] MUL = 5'h18, DIVU = 5'h19, REMU = 5'h1A;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  logic chk_on = 1'b0;
  int   tests = 0;
  int   fails = 0;

  cpu_execute_mc_if #(.DW(DW), .TW(TW), .IW(IW), .AW(AW), .PW(PW)) bus ();

  cpu_execute_mc #(.DW(DW), .TW(TW), .IW(IW), .AW(AW), .PW(PW)) dut (
    .clk(clk),
    .rst_b(rst_b),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: returns {cond, result}.
  function automatic logic [DW:0] single_op(input logic [4:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW-1:0] o;
    logic c;
    c = 1'b0;
    case (op)
      5'h00: o = a + b;
      5'h01: o = a - b;
      5'h02: o = a & b;
      5'h03: o = a | b;
      5'h04: o = a ^ b;
      5'h05: o = a << b[4:0];
      5'h06: o = a >> b[4:0];
      5'h07: o = (a < b) ? 1 : 0;
      5'h08: o = (a == b) ? 1 : 0;
      5'h19, 5'h1A: o = DivEn ? a : 0;
      default: o = a;
    endcase
    if (op == 5'h07 || op == 5'h08) c = o[0];
    else if (!DivEn && (op == 5'h19 || op == 5'h1A)) c = 1'b1;
    else c = (o == 0);
    return {c, o};
  endfunction

  function automatic logic [DW:0] multi_op(input logic [4:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    if (op == 5'h18) return {(p[63:32] != 0), p[31:0]};
    if (b == 0) return {1'b1, (op == 5'h19) ? 32'hFFFF_FFFF : a};
    return {1'b0, (op == 5'h19) ? a / b : a % b};
  endfunction

  int            m_k = 0;  // cycles spent by the current multi-cycle op; 0 = none
  logic [DW:0]   m_mres = '0;
  logic          e_valid = 0, e_cnd = 0, e_mw = 0;
  logic [DW-1:0] e_out = '0, e_pc = '0;
  logic [IW-1:0] e_instr = '0;
  logic [1:0]    e_branch = '0;
  logic [2:0]    e_push = '0;
  logic [AW-1:0] e_addr = '0;
  logic [TW-1:0] e_r0 = '0, e_r1 = '0;
  logic [PW-1:0] e_pop = '0;
  logic          m_mc, m_stall;
  logic [DW-1:0] m_a, m_b;

  function automatic logic [DW-1:0] pick(input logic [1:0] s, input logic [DW-1:0] alt);
    return (s == 0) ? bus.instruction_2a[DW-1:0] : (s == 1) ? bus.st_top_0_2a[DW-1:0] :
           (s == 2) ? bus.st_top_n_2a[DW-1:0] : alt;
  endfunction

  assign m_a     = pick(bus.c_alu_left_2a, bus.pc_1a);
  assign m_b     = pick(bus.c_alu_right_2a, e_r1[DW-1:0]);
  assign m_mc    = bus.valid_2a && (bus.alu_op_2a == MUL ||
                   (DivEn && (bus.alu_op_2a == DIVU || bus.alu_op_2a == REMU)));
  assign m_stall = rst_b && m_mc && (m_k != DW + 1);

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_k <= 0; m_mres <= '0; e_valid <= 0; e_cnd <= 0; e_mw <= 0; e_out <= '0; e_pc <= '0;
      e_instr <= '0; e_branch <= '0; e_push <= '0; e_addr <= '0; e_r0 <= '0; e_r1 <= '0;
      e_pop <= '0;
    end else begin
      if (!m_stall) begin
        e_valid  <= bus.valid_2a && !bus.kill_4a;
        {e_cnd, e_out} <= (m_k == DW + 1) ? m_mres : single_op(bus.alu_op_2a, m_a, m_b);
        e_pc     <= bus.pc_2a;
        e_instr  <= bus.instruction_2a;
        e_addr   <= bus.st_top_n_2a[AW-1:0];
        e_branch <= bus.kill_4a ? 2'd0 : bus.c_branch_2a;
        e_mw     <= bus.kill_4a ? 1'b0 : bus.c_mem_write_2a;
        e_push   <= bus.kill_4a ? 3'd0 : bus.c_to_push_2a;
        e_pop    <= bus.kill_4a ? '0 : bus.st_to_pop_2a;
        if (bus.c_r0_2a && !bus.kill_4a) e_r0 <= bus.st_top_0_2a;
        if (bus.c_r1_2a && !bus.kill_4a) e_r1 <= bus.st_top_n_2a;
      end else begin
        e_valid <= 0; e_branch <= '0; e_mw <= 0; e_push <= '0; e_pop <= '0;
      end
      if (m_k == 0) begin
        if (m_mc && !bus.kill_4a) begin
          m_k    <= 1;
          m_mres <= multi_op(bus.alu_op_2a, m_a, m_b);
        end
      end else if (bus.kill_4a || m_k == DW + 1) m_k <= 0;
      else m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("stall_2a", bus.stall_2a, m_stall);
      chk("valid_3a", bus.valid_3a, e_valid);
      chk("alu_out_3a", bus.alu_out_3a, e_out);
      chk("alu_cond_3a", bus.alu_cond_3a, e_cnd);
      chk("pc_3a", bus.pc_3a, e_pc);
      chk("instruction_3a", bus.instruction_3a, e_instr);
      chk("c_branch_3a", bus.c_branch_3a, e_branch);
      chk("c_mem_write_3a", bus.c_mem_write_3a, e_mw);
      chk("c_to_push_3a", bus.c_to_push_3a, e_push);
      chk("c_mem_addr_3a", bus.c_mem_addr_3a, e_addr);
      chk("r0_3a", bus.r0_3a, e_r0);
      chk("r1_3a", bus.r1_3a, e_r1);
      chk("st_to_pop_3a", bus.st_to_pop_3a, e_pop);
    end
  end

  task automatic setop(input logic [4:0] op, input logic [1:0] l, input logic [1:0] r,
                       input logic [DW-1:0] imm, input logic [TW-1:0] t0,
                       input logic [TW-1:0] tn, input logic cr0, input logic cr1);
    bus.valid_2a       = 1'b1;
    bus.alu_op_2a      = op;
    bus.c_alu_left_2a  = l;
    bus.c_alu_right_2a = r;
    bus.instruction_2a = {16'hA5C3, imm};
    bus.st_top_0_2a    = t0;
    bus.st_top_n_2a    = tn;
    bus.c_r0_2a        = cr0;
    bus.c_r1_2a        = cr1;
    bus.pc_2a          = bus.pc_2a + 4;
    bus.pc_1a          = bus.pc_2a + 4;
    bus.c_branch_2a    = 2'd2;
    bus.c_mem_write_2a = 1'b1;
    bus.c_to_push_2a   = 3'd5;
    bus.st_to_pop_2a   = 11'd7;
  endtask

  // Counts stalled cycles, then returns just after the edge that loads stage 3.
  task automatic wait_done(output int n);
    bit done;
    done = 0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.stall_2a) begin
        done = 1;
        break;
      end
      n++;
    end
    chk("stall_bounded", done, 1);
    @(posedge clk);
    #1;
  endtask

  int n;

  initial begin
    bus.valid_2a = 0; bus.alu_op_2a = 0; bus.c_alu_left_2a = 0; bus.c_alu_right_2a = 0;
    bus.c_branch_2a = 0; bus.c_mem_write_2a = 0; bus.c_to_push_2a = 0; bus.c_r0_2a = 0;
    bus.c_r1_2a = 0; bus.instruction_2a = 0; bus.pc_2a = 32'h100; bus.pc_1a = 32'h104;
    bus.st_top_0_2a = 0; bus.st_top_n_2a = 0; bus.st_to_pop_2a = 0; bus.kill_4a = 0;
    #2 rst_b = 0;
    chk_on = 1;
    #1;
    chk("reset_valid", bus.valid_3a, 0);
    chk("reset_out", bus.alu_out_3a, 0);
    chk("reset_stall", bus.stall_2a, 0);
    @(negedge clk);
    rst_b = 1;
    @(posedge clk);
    #1;

    setop(ADD, 2'd0, 2'd1, 32'd5, 35'h5_0000_0007, 35'h0, 1'b0, 1'b0);
    wait_done(n);
    chk("add_stalls", n, 0);
    chk("add_out", bus.alu_out_3a, 12);
    chk("add_valid", bus.valid_3a, 1);
    chk("add_branch", bus.c_branch_3a, 2);

    setop(SUB, 2'd2, 2'd1, 32'd0, 35'h7_0000_0010, 35'h3_0000_0030, 1'b1, 1'b1);
    wait_done(n);
    chk("sub_out", bus.alu_out_3a, 32'h20);
    chk("sub_r1", bus.r1_3a, 35'h3_0000_0030);

    setop(ADD, 2'd3, 2'd3, 32'd0, 35'h0, 35'h0, 1'b0, 1'b0);
    wait_done(n);
    chk("fwd_out", bus.alu_out_3a, bus.pc_1a + 32'h30);

    setop(LTU, 2'd0, 2'd1, 32'd3, 35'h4, 35'h0, 1'b0, 1'b0);
    wait_done(n);
    chk("ltu_out", bus.alu_out_3a, 1);
    chk("ltu_cond", bus.alu_cond_3a, 1);

    setop(MUL, 2'd0, 2'd1, 32'h0000_FFFF, 35'h0_0001_0001, 35'h1_0000_00AB, 1'b1, 1'b0);
    wait_done(n);
    chk("mul_stalls", n, 33);
    chk("mul_out", bus.alu_out_3a, 32'hFFFF_FFFF);
    chk("mul_cond", bus.alu_cond_3a, 0);
    chk("mul_valid", bus.valid_3a, 1);

    setop(MUL, 2'd0, 2'd1, 32'h0001_0000, 35'h0_0001_0000, 35'h0, 1'b0, 1'b0);
    wait_done(n);
    chk("mul_ovf_out", bus.alu_out_3a, 0);
    chk("mul_ovf_cond", bus.alu_cond_3a, 1);

    setop(DIVU, 2'd0, 2'd1, 32'd100, 35'd7, 35'h0, 1'b0, 1'b0);
    wait_done(n);
    chk("divu_stalls", n, DivEn ? 33 : 0);
    chk("divu_out", bus.alu_out_3a, DivEn ? 14 : 0);
    chk("divu_cond", bus.alu_cond_3a, DivEn ? 0 : 1);
    setop(REMU, 2'd0, 2'd1, 32'd100, 35'd7, 35'h0, 1'b0, 1'b0);
    wait_done(n);
    chk("remu_out", bus.alu_out_3a, DivEn ? 2 : 0);
    chk("remu_cond", bus.alu_cond_3a, DivEn ? 0 : 1);
    setop(DIVU, 2'd0, 2'd1, 32'd9, 35'd0, 35'h0, 1'b0, 1'b0);
    wait_done(n);
    chk("div0_out", bus.alu_out_3a, DivEn ? 32'hFFFF_FFFF : 0);
    chk("div0_cond", bus.alu_cond_3a, 1);

    setop(ADD, 2'd0, 2'd0, 32'd1, 35'h2_0000_1111, 35'h1_0000_2222, 1'b1, 1'b1);
    wait_done(n);
    setop(MUL, 2'd0, 2'd1, 32'd6, 35'h6_0000_0009, 35'h6_0000_0008, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1 bus.kill_4a = 1'b1;
    @(posedge clk);
    #1;
    bus.kill_4a  = 1'b0;
    bus.valid_2a = 1'b0;
    @(negedge clk);
    chk("kill_stall", bus.stall_2a, 0);
    chk("kill_valid", bus.valid_3a, 0);
    chk("kill_r0", bus.r0_3a, 35'h2_0000_1111);
    chk("kill_r1", bus.r1_3a, 35'h1_0000_2222);
    @(posedge clk);
    #1;
    setop(MUL, 2'd0, 2'd1, 32'd3, 35'd5, 35'h0, 1'b0, 1'b0);
    wait_done(n);
    chk("post_kill_stalls", n, 33);
    chk("post_kill_out", bus.alu_out_3a, 15);

    setop(DIVU, 2'd0, 2'd1, 32'd1000, 35'd10, 35'h0, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("rst_stall", bus.stall_2a, 0);
    chk("rst_valid", bus.valid_3a, 0);
    chk("rst_out", bus.alu_out_3a, 0);
    chk("rst_r0", bus.r0_3a, 0);
    chk("rst_pc", bus.pc_3a, 0);
    bus.valid_2a = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    setop(DIVU, 2'd0, 2'd1, 32'd1000, 35'd10, 35'h0, 1'b0, 1'b0);
    wait_done(n);
    chk("rst_divu_stalls", n, DivEn ? 33 : 0);
    chk("rst_divu_out", bus.alu_out_3a, DivEn ? 100 : 0);
    bus.valid_2a = 1'b0;
    @(posedge clk);
    #1;

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
